stopwatch_lap_core: RTL and testbench
=====================================

Name: stopwatch_lap_core

Overview:
- Parametrised successor to the board stopwatch counter: BCD time core in MM:SS:CC format with count-up and count-down modes, preset load, display freeze, and a circular lap buffer.
- Sits between the debounce/edge-detect front end and the sevenseg decoders.
- All control inputs are single-cycle, CLOCK_50-synchronous pulses that have already been debounced.
- Replaces the multi-clock-domain structure with one clock plus a tick enable.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 100, time resolution; 100 gives 1 centisecond. CLK_HZ must be divisible by TICK_HZ.
- LAP_DEPTH, 4, number of lap entries; must be at least 2.

Ports:
- CLOCK_50  in  1  system clock.
- key_reset  in  1  asynchronous, active-high reset.
- start_pause_p  in  1  pulse; toggles run/pause.
- clear_p  in  1  pulse; synchronous clear of time, laps and flags.
- lap_p  in  1  pulse; capture a lap.
- freeze_p  in  1  pulse; toggles display freeze.
- load_p  in  1  pulse; load preset_time, accepted only while paused.
- mode_down  in  1  selects counting direction: 1 = count down, 0 = count up. Sampled on each tick.
- preset_time  in  24  BCD value {m1,m0,s1,s0,c1,c0}.
- lap_rd_idx  in  $clog2(LAP_DEPTH)  0 = newest lap.
- disp_time  out  24  BCD display value, drives the 6 sevenseg instances.
- live_time  out  24  BCD running counter.
- lap_rd_data  out  24  BCD lap entry; 1-cycle read latency.
- lap_count  out  $clog2(LAP_DEPTH+1)  number of valid laps; saturates at LAP_DEPTH.
- running  out  1  high while counting.
- frozen  out  1  high while the display is frozen.
- expired  out  1  sticky; set when count-down reaches zero.
- overflow  out  1  sticky; set when count-up saturates at 99:59:99.

Behaviour:
- Reset (async, key_reset=1): all outputs and internal state are 0. This includes the divider, the lap buffer write pointer and all flags.
- Tick generation:
  - The divider counts 0..CLK_HZ/TICK_HZ-1 only while running=1, and holds its value while paused (phase is preserved).
  - tick is asserted for 1 cycle at the terminal count.
- Counting digit rules on tick:
  - c0 0-9, c1 0-9, s0 0-9, s1 0-5, m0 0-9, m1 0-9.
  - Carry or borrow ripples within the same cycle, so live_time updates on the cycle after the tick.
- Count-up limit:
  - At 99:59:99 a tick holds the value, sets overflow and clears running.
- Count-down limit:
  - A tick at 00:00:01 gives 00:00:00, sets expired and clears running.
  - start_pause_p while live_time=0 and mode_down=1 is ignored.
- start_pause_p: toggles running, except when blocked by the count-down rule above.
- load_p:
  - When running=0, live_time takes preset_time on the next cycle. Any BCD digit above its maximum is clamped to that maximum.
  - Clears expired and overflow. Ignored while running=1.
- lap_p while running=1:
  - Writes the current registered live_time (the pre-tick value if a tick occurs in the same cycle) to buf[wr_ptr].
  - wr_ptr increments modulo LAP_DEPTH; lap_count increments until it saturates.
  - When full, the oldest entry is overwritten.
  - Ignored while paused.
- lap_rd_data:
  - Returns buf[(wr_ptr-1-lap_rd_idx) mod LAP_DEPTH], registered.
  - When lap_rd_idx >= lap_count, returns 0.
- freeze_p:
  - Toggles frozen.
  - While frozen=0, disp_time follows live_time with 1 cycle of latency.
  - While frozen=1, disp_time holds its value; counting continues underneath.
- clear_p:
  - Zeroes live_time, disp_time, lap_count, wr_ptr, the divider, running, expired and overflow. frozen is unchanged.
- Same-cycle priority: reset > clear_p > load_p > start_pause_p/lap_p > tick.
  - lap_p together with start_pause_p (run to pause) still captures the lap.
  - lap_p together with start_pause_p (pause to run) is ignored.
- Mid-operation:
  - A mode_down change while running takes effect on the next tick, with no glitch.
  - key_reset mid-count returns all state to its reset values immediately.

Decomposition:
- Shared package stopwatch_pkg:
  - typedef bcd_time_t, a 24-bit packed struct {m1,m0,s1,s0,c1,c0}.
  - Digit maximum constants.
  - BCD_ZERO and BCD_MAX (99:59:99).
  - Helper functions bcd_inc/bcd_dec.
- One sub-module: tick_divider (params CLK_HZ, TICK_HZ; ports CLOCK_50, key_reset, en, clr, tick).
- The lap buffer is a register array inside the core, with no separate module.

Test Plan:
- Sim params CLK_HZ=1000, TICK_HZ=100 (divide by 10). Reset, then start_pause_p -> first tick after 10 cycles; after 1000 cycles live_time=00:01:00, running=1.
- Preset 00:59:99, count up, 1 tick -> 01:00:00. Preset 99:59:98, 2 ticks -> holds 99:59:99, overflow=1, running=0.
- mode_down=1, preset 00:00:03, start -> 00:00:00 after 30 cycles, expired=1. Further start_pause_p is ignored. load_p clears expired.
- LAP_DEPTH=4, 5 lap_p pulses at 1, 2, 3, 4, 5 ticks -> lap_count=4; idx0=00:00:05, idx3=00:00:02. lap_p while paused -> no change.
- freeze_p at 00:00:20, run to 00:00:50 -> disp_time=00:00:20. Second freeze_p -> disp_time=00:00:50 one cycle later.
- Same-cycle clear_p + lap_p + tick -> all zero, lap_count=0. key_reset asserted mid-count -> outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/stopwatch_lap_core_pkg.sv
// Shared types and BCD helpers for the stopwatch lap core.
// MM:SS:CC time is six BCD nibbles, c0 in the low nibble.
package stopwatch_pkg;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] c1;
    logic [3:0] c0;
  } bcd_time_t;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } run_st_e;

  localparam logic [3:0] C0_MAX = 4'd9;
  localparam logic [3:0] C1_MAX = 4'd9;
  localparam logic [3:0] S0_MAX = 4'd9;
  localparam logic [3:0] S1_MAX = 4'd5;
  localparam logic [3:0] M0_MAX = 4'd9;
  localparam logic [3:0] M1_MAX = 4'd9;

  localparam bcd_time_t BCD_ZERO = '0;
  localparam bcd_time_t BCD_MAX = {
    M1_MAX, M0_MAX, S1_MAX,
    S0_MAX, C1_MAX, C0_MAX
  };
  localparam logic [23:0] DIG_MAX = BCD_MAX;

  function automatic bcd_time_t bcd_inc(
    input bcd_time_t t
  );
    logic [23:0] v;
    logic        c;
    v = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (v[i*4 +: 4] >= DIG_MAX[i*4 +: 4]) begin
          v[i*4 +: 4] = 4'd0;
        end else begin
          v[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return bcd_time_t'(v);
  endfunction

  function automatic bcd_time_t bcd_dec(
    input bcd_time_t t
  );
    logic [23:0] v;
    logic        b;
    v = t;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) begin
          v[i*4 +: 4] = DIG_MAX[i*4 +: 4];
        end else begin
          v[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return bcd_time_t'(v);
  endfunction

  function automatic bcd_time_t bcd_clamp(
    input bcd_time_t t
  );
    logic [23:0] v;
    v = t;
    for (int i = 0; i < 6; i++) begin
      if (v[i*4 +: 4] > DIG_MAX[i*4 +: 4])
        v[i*4 +: 4] = DIG_MAX[i*4 +: 4];
    end
    return bcd_time_t'(v);
  endfunction

endpackage

// File: rtl/stopwatch_lap_core_if.sv
// Control pulses and status/time outputs between the
// debounce front end (master) and the stopwatch core (slave).
interface stopwatch_lap_core_if #(
  parameter int LAP_DEPTH = 4
);
  import stopwatch_pkg::*;

  localparam int PW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  logic          start_pause_p;
  logic          clear_p;
  logic          lap_p;
  logic          freeze_p;
  logic          load_p;
  logic          mode_down;
  bcd_time_t     preset_time;
  logic [PW-1:0] lap_rd_idx;

  bcd_time_t     disp_time;
  bcd_time_t     live_time;
  bcd_time_t     lap_rd_data;
  logic [CW-1:0] lap_count;
  logic          running;
  logic          frozen;
  logic          expired;
  logic          overflow;

  modport master (
    output start_pause_p, clear_p, lap_p,
    output freeze_p, load_p, mode_down,
    output preset_time, lap_rd_idx,
    input  disp_time, live_time, lap_rd_data,
    input  lap_count, running, frozen,
    input  expired, overflow
  );

  modport slave (
    input  start_pause_p, clear_p, lap_p,
    input  freeze_p, load_p, mode_down,
    input  preset_time, lap_rd_idx,
    output disp_time, live_time, lap_rd_data,
    output lap_count, running, frozen,
    output expired, overflow
  );

endinterface

// File: rtl/stopwatch_lap_core_tick_divider.sv
// Clock-enable divider: one-cycle tick every CLK_HZ/TICK_HZ
// enabled cycles; phase is held while disabled.
module tick_divider #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic CLOCK_50,
  input  logic key_reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tick ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge key_reset) begin
    if (key_reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_lap_core.sv
// BCD MM:SS:CC stopwatch core: up/down count, preset load,
// display freeze and a circular lap buffer.
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 4
) (
  input logic CLOCK_50,
  input logic key_reset,
  stopwatch_lap_core_if.slave bus
);

  localparam int PW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   sum_t;
  typedef logic [CW-1:0] cnt_t;

  run_st_e   state_q, state_d;
  bcd_time_t live_q, live_d;
  bcd_time_t disp_q, disp_d;
  bcd_time_t rd_q, rd_d;
  bcd_time_t laps_q [LAP_DEPTH];
  ptr_t      wr_q, wr_d;
  cnt_t      cnt_q, cnt_d;
  logic      frz_q, frz_d;
  logic      exp_q, exp_d;
  logic      ovf_q, ovf_d;
  logic      lap_we;
  logic      tick;
  logic      run;
  logic      start_ok;
  sum_t      rd_sum;
  ptr_t      rd_ptr;

  tick_divider #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_div (
    .CLOCK_50 (CLOCK_50),
    .key_reset(key_reset),
    .en       (run),
    .clr      (bus.clear_p),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50 or posedge key_reset) begin
    if (key_reset)
      state_q <= ST_PAUSE;
    else
      state_q <= state_d;
  end

  // A paused count-down sitting at zero cannot be restarted.
  assign start_ok = bus.start_pause_p &&
    !(state_q == ST_PAUSE && bus.mode_down &&
      live_q == BCD_ZERO);

  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    ovf_d   = ovf_q;
    lap_we  = 1'b0;
    if (bus.clear_p) begin
      state_d = ST_PAUSE;
      live_d  = BCD_ZERO;
      wr_d    = '0;
      cnt_d   = '0;
      exp_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (bus.load_p && state_q == ST_PAUSE) begin
      live_d = bcd_clamp(bus.preset_time);
      exp_d  = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (bus.lap_p && state_q == ST_RUN) begin
        lap_we = 1'b1;
        wr_d = (wr_q == ptr_t'(LAP_DEPTH - 1)) ?
               '0 : wr_q + ptr_t'(1);
        if (cnt_q != cnt_t'(LAP_DEPTH))
          cnt_d = cnt_q + cnt_t'(1);
      end
      if (start_ok) begin
        state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end else if (tick) begin
        if (bus.mode_down) begin
          if (live_q == BCD_ZERO ||
              bcd_dec(live_q) == BCD_ZERO) begin
            live_d  = BCD_ZERO;
            exp_d   = 1'b1;
            state_d = ST_PAUSE;
          end else begin
            live_d = bcd_dec(live_q);
          end
        end else if (live_q == BCD_MAX) begin
          ovf_d   = 1'b1;
          state_d = ST_PAUSE;
        end else begin
          live_d = bcd_inc(live_q);
        end
      end
    end
  end

  // Newest lap sits one behind the write pointer.
  always_comb begin
    rd_sum = sum_t'({1'b0, wr_q}) +
             sum_t'(LAP_DEPTH - 1) -
             sum_t'({1'b0, bus.lap_rd_idx});
    if (rd_sum >= sum_t'(LAP_DEPTH))
      rd_sum = rd_sum - sum_t'(LAP_DEPTH);
    rd_ptr = rd_sum[PW-1:0];
  end

  always_comb begin
    frz_d  = frz_q ^ bus.freeze_p;
    disp_d = frz_q ? disp_q : live_q;
    rd_d   = BCD_ZERO;
    if (cnt_t'(bus.lap_rd_idx) < cnt_q)
      rd_d = laps_q[rd_ptr];
    if (bus.clear_p) begin
      disp_d = BCD_ZERO;
      rd_d   = BCD_ZERO;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge key_reset) begin
    if (key_reset) begin
      live_q <= BCD_ZERO;
      disp_q <= BCD_ZERO;
      rd_q   <= BCD_ZERO;
      wr_q   <= '0;
      cnt_q  <= '0;
      frz_q  <= 1'b0;
      exp_q  <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++)
        laps_q[i] <= BCD_ZERO;
    end else begin
      live_q <= live_d;
      disp_q <= disp_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      frz_q  <= frz_d;
      exp_q  <= exp_d;
      ovf_q  <= ovf_d;
      if (lap_we)
        laps_q[wr_q] <= live_q;
    end
  end

  always_comb begin
    run = (state_q == ST_RUN);
    bus.running = run;
  end

  assign bus.live_time   = live_q;
  assign bus.disp_time   = disp_q;
  assign bus.lap_rd_data = rd_q;
  assign bus.lap_count   = cnt_q;
  assign bus.frozen      = frz_q;
  assign bus.expired     = exp_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Self-checking bench for stopwatch_lap_core at a
// divide-by-10 tick (CLK_HZ=1000, TICK_HZ=100).
module tb_stopwatch_lap_core;
  import stopwatch_pkg::*;

  localparam int P_START  = 0;
  localparam int P_CLEAR  = 1;
  localparam int P_LAP    = 2;
  localparam int P_FREEZE = 3;
  localparam int P_LOAD   = 4;

  typedef struct {
    logic [23:0] preset;
    logic [23:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [1:0]  idx;
    logic [23:0] exp;
  } rd_vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [23:0] sbq [$];
  ld_vec_t ld_tab [6];
  rd_vec_t rd_tab [4];

  stopwatch_lap_core_if #(.LAP_DEPTH(4)) bus ();

  stopwatch_lap_core #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .LAP_DEPTH(4)
  ) dut (
    .CLOCK_50 (clk),
    .key_reset(rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [23:0] act,
                     input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic pulse(input int s);
    @(negedge clk);
    case (s)
      P_START:  bus.start_pause_p = 1'b1;
      P_CLEAR:  bus.clear_p = 1'b1;
      P_LAP:    bus.lap_p = 1'b1;
      P_FREEZE: bus.freeze_p = 1'b1;
      default:  bus.load_p = 1'b1;
    endcase
    @(negedge clk);
    bus.start_pause_p = 1'b0;
    bus.clear_p = 1'b0;
    bus.lap_p = 1'b0;
    bus.freeze_p = 1'b0;
    bus.load_p = 1'b0;
  endtask

  task automatic load_chk(input logic [23:0] p,
                          input logic [23:0] e,
                          input string nm);
    @(negedge clk);
    bus.preset_time = p;
    bus.load_p = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    bus.load_p = 1'b0;
    chk(nm, bus.live_time, sbq.pop_front());
  endtask

  task automatic rd_chk(input logic [1:0] idx,
                        input logic [23:0] e,
                        input string nm);
    @(negedge clk);
    bus.lap_rd_idx = idx;
    sbq.push_back(e);
    @(negedge clk);
    chk(nm, bus.lap_rd_data, sbq.pop_front());
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ld_tab[0] = '{24'h005999, 24'h005999};
    ld_tab[1] = '{24'hFFFFFF, 24'h995999};
    ld_tab[2] = '{24'h07A9BC, 24'h075999};
    ld_tab[3] = '{24'h123456, 24'h123456};
    ld_tab[4] = '{24'h996999, 24'h995999};
    ld_tab[5] = '{24'h000003, 24'h000003};
    rd_tab[0] = '{2'd0, 24'h000005};
    rd_tab[1] = '{2'd1, 24'h000004};
    rd_tab[2] = '{2'd2, 24'h000003};
    rd_tab[3] = '{2'd3, 24'h000002};

    rst = 1'b1;
    bus.start_pause_p = 1'b0;
    bus.clear_p = 1'b0;
    bus.lap_p = 1'b0;
    bus.freeze_p = 1'b0;
    bus.load_p = 1'b0;
    bus.mode_down = 1'b0;
    bus.preset_time = '0;
    bus.lap_rd_idx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_live", bus.live_time, 24'h0);
    chk("rst_disp", bus.disp_time, 24'h0);
    chk("rst_lapd", bus.lap_rd_data, 24'h0);
    chk("rst_flags",
        {bus.lap_count, bus.running, bus.frozen,
         bus.expired, bus.overflow}, 24'h0);

    // Free run: 100 ticks of 10 cycles each.
    pulse(P_START);
    repeat (999) @(negedge clk);
    chk("run_999", bus.live_time, 24'h000099);
    @(negedge clk);
    chk("run_1000", bus.live_time, 24'h000100);
    chk("run_flag", bus.running, 1'b1);
    pulse(P_START);
    pulse(P_CLEAR);
    chk("clr_live", bus.live_time, 24'h0);

    for (int i = 0; i < 6; i++)
      load_chk(ld_tab[i].preset, ld_tab[i].exp,
               $sformatf("load_%0d", i));

    pulse(P_CLEAR);
    load_chk(24'h005999, 24'h005999, "pre_carry");
    pulse(P_START);
    repeat (10) @(negedge clk);
    chk("carry_up", bus.live_time, 24'h010000);
    pulse(P_START);

    pulse(P_CLEAR);
    load_chk(24'h995998, 24'h995998, "pre_ovf");
    pulse(P_START);
    repeat (10) @(negedge clk);
    chk("ovf_t1", bus.live_time, 24'h995999);
    chk("ovf_t1_flag", bus.overflow, 1'b0);
    repeat (10) @(negedge clk);
    chk("ovf_t2", bus.live_time, 24'h995999);
    chk("ovf_flag", bus.overflow, 1'b1);
    chk("ovf_stop", bus.running, 1'b0);

    bus.mode_down = 1'b1;
    pulse(P_CLEAR);
    load_chk(24'h000003, 24'h000003, "pre_down");
    pulse(P_START);
    repeat (30) @(negedge clk);
    chk("down_zero", bus.live_time, 24'h0);
    chk("down_exp", bus.expired, 1'b1);
    chk("down_stop", bus.running, 1'b0);
    pulse(P_START);
    chk("down_blk", bus.running, 1'b0);
    pulse(P_LOAD);
    chk("load_clr_exp", bus.expired, 1'b0);
    chk("load_live", bus.live_time, 24'h000003);
    bus.mode_down = 1'b0;

    pulse(P_CLEAR);
    rd_chk(2'd0, 24'h0, "rd_empty");
    pulse(P_START);
    for (int k = 1; k <= 5; k++) begin
      repeat (10) @(negedge clk);
      bus.lap_p = 1'b1;
      @(negedge clk);
      bus.lap_p = 1'b0;
    end
    pulse(P_START);
    chk("lap_cnt", bus.lap_count, 24'd4);
    for (int i = 0; i < 4; i++)
      rd_chk(rd_tab[i].idx, rd_tab[i].exp,
             $sformatf("lap_rd%0d", i));
    pulse(P_LAP);
    chk("lap_paused", bus.lap_count, 24'd4);
    rd_chk(2'd0, 24'h000005, "lap_paused_rd");

    pulse(P_CLEAR);
    pulse(P_START);
    repeat (200) @(negedge clk);
    bus.freeze_p = 1'b1;
    @(negedge clk);
    bus.freeze_p = 1'b0;
    repeat (299) @(negedge clk);
    chk("frz_live", bus.live_time, 24'h000050);
    chk("frz_disp", bus.disp_time, 24'h000020);
    chk("frz_flag", bus.frozen, 1'b1);
    bus.freeze_p = 1'b1;
    @(negedge clk);
    bus.freeze_p = 1'b0;
    @(negedge clk);
    chk("unfrz_disp", bus.disp_time, 24'h000050);

    // Clear and lap land on the same edge as a tick.
    repeat (7) @(negedge clk);
    bus.clear_p = 1'b1;
    bus.lap_p = 1'b1;
    @(negedge clk);
    bus.clear_p = 1'b0;
    bus.lap_p = 1'b0;
    chk("cl_live", bus.live_time, 24'h0);
    chk("cl_disp", bus.disp_time, 24'h0);
    chk("cl_cnt", bus.lap_count, 24'h0);
    chk("cl_run", bus.running, 1'b0);

    pulse(P_START);
    repeat (12) @(negedge clk);
    pulse(P_LAP);
    pulse(P_FREEZE);
    repeat (10) @(negedge clk);
    chk("pre_rst_live", bus.live_time, 24'h000002);
    chk("pre_rst_cnt", bus.lap_count, 24'd1);
    rst = 1'b1;
    #1;
    chk("arst_live", bus.live_time, 24'h0);
    chk("arst_disp", bus.disp_time, 24'h0);
    chk("arst_flags",
        {bus.lap_count, bus.running, bus.frozen,
         bus.expired, bus.overflow}, 24'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
